// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - decoder-to-fetch bus for fetch_pc_ctrl
//
// Purpose: groups the decoder strobes, instruction fields and register
// operands consumed by the fetch stage, plus the PC values it returns.
// Ports (via modports):
//   master : drives beq/bne/bltz/jmp/jal/jr/syscall_halt, alu_equal,
//            rs_negative, imm16, jtarget, jr_addr; reads pc, pc_plus4, imem_addr
//   slave  : the fetch stage, opposite directions
interface fetch_pc_ctrl_if #(
    parameter int IADDR_W = 10
);
    logic               beq;
    logic               bne;
    logic               bltz;
    logic               jmp;
    logic               jal;
    logic               jr;
    logic               syscall_halt;
    logic               alu_equal;
    logic               rs_negative;
    logic [15:0]        imm16;
    logic [25:0]        jtarget;
    logic [31:0]        jr_addr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic [IADDR_W-1:0] imem_addr;

    modport master (
        output beq, bne, bltz, jmp, jal, jr, syscall_halt,
        output alu_equal, rs_negative, imm16, jtarget, jr_addr,
        input  pc, pc_plus4, imem_addr
    );

    modport slave (
        input  beq, bne, bltz, jmp, jal, jr, syscall_halt,
        input  alu_equal, rs_negative, imm16, jtarget, jr_addr,
        output pc, pc_plus4, imem_addr
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - PC register, next-PC select, RUN/HALT machine, perf counters
//
// Purpose: instruction-fetch / next-PC stage of a single-cycle MIPS datapath.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   go           : resume request, acts on its rising edge while halted
//   step         : (SINGLE_STEP_EN only) execute one instruction while halted
//   bus (slave)  : decoder strobes/fields in; pc, pc_plus4, imem_addr out
//   halted       : 1 while halted
//   cycle_cnt    : instructions executed
//   jump_cnt     : executed j/jal/jr
//   branch_cnt   : taken conditional branches
// Optional feature macro: SINGLE_STEP_EN (adds step input and STEP state).
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IADDR_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    fetch_pc_ctrl_if.slave        bus,
    output logic                  halted,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           jump_cnt,
    output logic [31:0]           branch_cnt
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;
`else
    typedef enum logic [0:0] {S_RUN, S_HALT} state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_jump_cnt;
    logic [31:0] r_branch_cnt;
    logic        r_go_q;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_is_jump;
    logic        w_go_rise;
    logic        w_exec;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_tgt   = w_pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign w_j_tgt    = {w_pc_plus4[31:28], bus.jtarget, 2'b00};
    assign w_taken    = (bus.beq & bus.alu_equal) | (bus.bne & ~bus.alu_equal) |
                        (bus.bltz & bus.rs_negative);
    assign w_is_jump  = bus.jr | bus.jmp | bus.jal;
    assign w_go_rise  = go & ~r_go_q;

`ifdef SINGLE_STEP_EN
    logic r_step_q;
    logic w_step_rise;
    assign w_step_rise = step & ~r_step_q;
    // A STEP cycle executes with exactly the same rules as a RUN cycle.
    assign w_exec      = (r_state == S_RUN) || (r_state == S_STEP);
`else
    assign w_exec      = (r_state == S_RUN);
`endif

    // Priority chain keeps the result defined for illegal multi-strobe inputs.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (bus.jr)
            w_next_pc = bus.jr_addr;
        else if (bus.jmp || bus.jal)
            w_next_pc = w_j_tgt;
        else if (w_taken)
            w_next_pc = w_br_tgt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:  if (bus.syscall_halt) w_state_nxt = S_HALT;
            S_HALT: begin
                if (w_go_rise)
                    w_state_nxt = S_RUN;
`ifdef SINGLE_STEP_EN
                else if (w_step_rise)
                    w_state_nxt = S_STEP;
`endif
            end
`ifdef SINGLE_STEP_EN
            S_STEP: w_state_nxt = S_HALT;
`endif
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_go_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_go_q  <= go;
        end
    end

`ifdef SINGLE_STEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_step_q <= 1'b0;
        else
            r_step_q <= step;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_cycle_cnt  <= 32'd0;
            r_jump_cnt   <= 32'd0;
            r_branch_cnt <= 32'd0;
        end else if (w_exec) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (bus.syscall_halt) begin
                // Halting syscall retires like a plain instruction; control
                // strobes are ignored so the held pc is the one after it.
                r_pc <= w_pc_plus4;
            end else begin
                r_pc <= w_next_pc;
                if (w_is_jump)
                    r_jump_cnt <= r_jump_cnt + 32'd1;
                if (w_taken)
                    r_branch_cnt <= r_branch_cnt + 32'd1;
            end
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_plus4  = w_pc_plus4;
    assign bus.imem_addr = r_pc[IADDR_W+1:2];
    assign halted        = (r_state == S_HALT);
    assign cycle_cnt     = r_cycle_cnt;
    assign jump_cnt      = r_jump_cnt;
    assign branch_cnt    = r_branch_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - scoreboard testbench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
    localparam int M_RUN  = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;
`ifdef SINGLE_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cyc;
        logic [31:0] jmp;
        logic [31:0] br;
        logic        halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        step = 1'b0;
    logic        halted;
    logic [31:0] cycle_cnt, jump_cnt, branch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q[$];

    // Reference model state
    logic [31:0] m_pc, m_cyc, m_jmp, m_br;
    int          m_mode;
    logic        m_goq, m_stepq;

    fetch_pc_ctrl_if #(.IADDR_W(10)) bus();

    fetch_pc_ctrl #(.RESET_PC(32'h0), .IADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .bus        (bus),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .jump_cnt   (jump_cnt),
        .branch_cnt (branch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_cyc = 0; m_jmp = 0; m_br = 0;
        m_mode = M_RUN; m_goq = 0; m_stepq = 0;
    endtask

    // One clock edge of the architectural behaviour, using current inputs.
    task automatic model_edge();
        logic        gr, sr, tk;
        logic [31:0] nxt, p4;
        gr = go & ~m_goq;
        sr = step & ~m_stepq;
        if (m_mode != M_HALT) begin
            m_cyc = m_cyc + 1;
            p4 = m_pc + 4;
            if (bus.syscall_halt) begin
                m_pc = p4;
                m_mode = M_HALT;
            end else begin
                tk = (bus.beq && bus.alu_equal) || (bus.bne && !bus.alu_equal) ||
                     (bus.bltz && bus.rs_negative);
                if (bus.jr)                  nxt = bus.jr_addr;
                else if (bus.jmp || bus.jal) nxt = (p4 & 32'hF000_0000) | (32'(bus.jtarget) * 4);
                else if (tk)                 nxt = p4 + 32'($signed(bus.imm16)) * 4;
                else                         nxt = p4;
                if (bus.jr || bus.jmp || bus.jal) m_jmp = m_jmp + 1;
                if (tk) m_br = m_br + 1;
                m_pc = nxt;
                if (m_mode == M_STEP) m_mode = M_HALT;
            end
        end else if (gr) begin
            m_mode = M_RUN;
        end else if (sr && STEP_EN) begin
            m_mode = M_STEP;
        end
        m_goq = go;
        m_stepq = step;
    endtask

    task automatic cyc();
        exp_t e;
        model_edge();
        e.pc = m_pc; e.cyc = m_cyc; e.jmp = m_jmp; e.br = m_br;
        e.halted = (m_mode == M_HALT);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic clr();
        bus.beq = 0; bus.bne = 0; bus.bltz = 0; bus.jmp = 0; bus.jal = 0; bus.jr = 0;
        bus.syscall_halt = 0; bus.alu_equal = 0; bus.rs_negative = 0;
        bus.imm16 = 0; bus.jtarget = 0; bus.jr_addr = 0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        clr(); bus.jr = 1; bus.jr_addr = a; cyc(); clr();
    endtask

    // Monitor: the DUT presents a new state every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_pc",        bus.pc,            e.pc);
                chk("sb_pc_plus4",  bus.pc_plus4,      e.pc + 32'd4);
                chk("sb_imem_addr", 32'(bus.imem_addr), 32'(e.pc[11:2]));
                chk("sb_halted",    32'(halted),       32'(e.halted));
                chk("sb_cycle_cnt", cycle_cnt,         e.cyc);
                chk("sb_jump_cnt",  jump_cnt,          e.jmp);
                chk("sb_branch_cnt", branch_cnt,       e.br);
            end
        end
    end

    initial begin
        clr();
        model_reset();
        #11;
        chk("rst_pc",     bus.pc,     32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_cyc",    cycle_cnt,  32'h0);
        chk("rst_jmp",    jump_cnt,   32'h0);
        chk("rst_br",     branch_cnt, 32'h0);
        #1 rst_n = 1;

        repeat (4) cyc();
        chk("tp_pc_0x10",  bus.pc, 32'h10);
        chk("tp_imem_4",   32'(bus.imem_addr), 32'd4);
        chk("tp_cyc_4",    cycle_cnt, 32'd4);

        jump_to(32'h20);
        bus.beq = 1; bus.alu_equal = 1; bus.imm16 = 16'hFFFE; cyc(); clr();
        chk("tp_beq_taken", bus.pc, 32'h1C);
        jump_to(32'h20);
        bus.beq = 1; bus.alu_equal = 0; bus.imm16 = 16'hFFFE; cyc(); clr();
        chk("tp_beq_not", bus.pc, 32'h24);

        jump_to(32'h3000_0040);
        chk("tp_pc_plus4", bus.pc_plus4, 32'h3000_0044);
        bus.jal = 1; bus.jtarget = 26'h0000100; cyc(); clr();
        chk("tp_jal", bus.pc, 32'h3000_0400);
        bus.jr = 1; bus.jmp = 1; bus.jr_addr = 32'h80; cyc(); clr();
        chk("tp_jr_prio", bus.pc, 32'h80);

        jump_to(32'h50);
        bus.syscall_halt = 1; bus.bne = 1; go = 1; cyc(); clr();
        chk("tp_halt_pc", bus.pc, 32'h54);
        chk("tp_halted",  32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            bus.bne = 1; bus.alu_equal = i[0]; bus.jmp = i[1]; cyc();
        end
        clr();
        chk("tp_go_held", 32'(halted), 32'h1);
        go = 0; cyc();
        go = 1; cyc();
        chk("tp_resumed", 32'(halted), 32'h0);
        cyc();
        chk("tp_resume_pc", bus.pc, 32'h58);

        for (int i = 0; i < 400; i++) begin
            bus.beq  = ($urandom_range(0, 3) == 0);
            bus.bne  = ($urandom_range(0, 3) == 0);
            bus.bltz = ($urandom_range(0, 3) == 0);
            bus.jmp  = ($urandom_range(0, 5) == 0);
            bus.jal  = ($urandom_range(0, 5) == 0);
            bus.jr   = ($urandom_range(0, 5) == 0);
            bus.syscall_halt = ($urandom_range(0, 19) == 0);
            bus.alu_equal    = 1'($urandom);
            bus.rs_negative  = 1'($urandom);
            bus.imm16   = 16'($urandom);
            bus.jtarget = 26'($urandom);
            bus.jr_addr = $urandom;
            if ($urandom_range(0, 3) == 0) go = ~go;
            step = STEP_EN ? ($urandom_range(0, 3) == 0) : 1'b0;
            cyc();
        end
        clr(); step = 0; go = 0;
        cyc();

        // Ensure halted with counters nonzero, then reset without a clock edge.
        bus.syscall_halt = 1; cyc(); clr();
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_pc",     bus.pc,     32'h0);
        chk("mid_rst_halted", 32'(halted), 32'h0);
        chk("mid_rst_cyc",    cycle_cnt,  32'h0);
        chk("mid_rst_jmp",    jump_cnt,   32'h0);
        chk("mid_rst_br",     branch_cnt, 32'h0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1;
        repeat (3) cyc();

`ifdef SINGLE_STEP_EN
        jump_to(32'h50);
        bus.syscall_halt = 1; cyc(); clr();
        step = 1; cyc();
        chk("st_in_step", 32'(halted), 32'h0);
        cyc();
        chk("st_pc", bus.pc, 32'h58);
        chk("st_rehalt", 32'(halted), 32'h1);
        step = 0; cyc();
        go = 1; step = 1; cyc();
        chk("st_go_prio", 32'(halted), 32'h0);
        go = 0; step = 0;
        repeat (2) cyc();
`endif

        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Instruction-fetch / next-PC stage of the single-cycle MIPS datapath. Holds the PC and drives the instruction memory address; the fetched instruction's op/func feed the control decoder.
- Consumes the decoder's branch/jump/syscall strobes, selects the next PC, and runs the RUN/HALT machine for halting syscalls.
- Maintains the performance counters shown on the board display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- IADDR_W, 10, instruction-memory word-address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  resume request, synchronous level; acts on its rising edge
- beq  in  1  decoder: beq
- bne  in  1  decoder: bne
- bltz  in  1  decoder: bltz
- jmp  in  1  decoder: j
- jal  in  1  decoder: jal
- jr  in  1  decoder: jr
- syscall_halt  in  1  decoder syscall AND $v0==10 (qualified outside)
- alu_equal  in  1  ALU equal flag (rs==rt)
- rs_negative  in  1  rs[31]
- imm16  in  16  instr[15:0]
- jtarget  in  26  instr[25:0]
- jr_addr  in  32  rs register value
- pc  out  32  current PC
- pc_plus4  out  32  pc+4, combinational; jal link value
- imem_addr  out  IADDR_W  pc[IADDR_W+1:2]
- halted  out  1  1 while in HALT
- cycle_cnt  out  32  instructions executed
- jump_cnt  out  32  executed j/jal/jr
- branch_cnt  out  32  taken conditional branches

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=RUN, halted=0.
  - All counters 0; go_q=0.
- go edge detect:
  - go_q<=go every cycle in every state.
  - go_rise = go & ~go_q.
- Branch condition: taken = beq&alu_equal | bne&~alu_equal | bltz&rs_negative.
- Targets:
  - br_tgt = pc_plus4 + ({{14{imm16[15]}},imm16,2'b00}), 32-bit wrap.
  - j_tgt = {pc_plus4[31:28], jtarget, 2'b00}.
- next_pc priority: jr -> jr_addr; else jmp|jal -> j_tgt; else taken -> br_tgt; else pc_plus4. Defined even for illegal multi-strobe combinations.
- State RUN, each clock edge:
  - pc<=next_pc; cycle_cnt+=1.
  - jump_cnt+=1 if jr|jmp|jal; branch_cnt+=1 if taken.
  - If syscall_halt: pc<=pc_plus4, cycle_cnt+=1, state<=HALT, halted<=1. Branch/jump strobes are ignored that cycle.
- State HALT:
  - pc and all counters frozen; decoder strobes ignored.
  - On go_rise: state<=RUN, halted<=0. The first RUN edge executes the instruction at the held pc.
- Simultaneous events:
  - go held high while entering HALT does not resume; a fresh rising edge is required.
  - go_rise while in RUN has no effect.
- Counters wrap 32'hFFFF_FFFF -> 0 silently.
- pc is not forced to word alignment; jr_addr is passed unmodified. imem_addr drops bits [1:0].
- Reset mid-operation (RUN or HALT) returns to reset values asynchronously. The first edge after release is a normal RUN fetch from RESET_PC.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) with its own edge detect (step_q).
  - Adds state STEP. In HALT, step_rise (go_rise has priority if both) -> STEP.
  - STEP executes exactly one instruction with RUN rules (next_pc, counters, halting syscall), then returns to HALT with halted=1.
  - halted reads 0 only during the STEP cycle.
- Undefined: no step port, no STEP state; behaviour as above.

Test Plan:
- Reset release with RESET_PC=0, no strobes, 4 clocks -> pc=0x10, imem_addr=4, cycle_cnt=4, jump_cnt=0, branch_cnt=0.
- pc=0x20, beq=1, alu_equal=1, imm16=16'hFFFE -> next pc=0x1C, branch_cnt+1. Same with alu_equal=0 -> pc=0x24, branch_cnt unchanged.
- pc=0x3000_0040, jal=1, jtarget=26'h0000100 -> pc=0x3000_0400, pc_plus4=0x3000_0044 before the edge, jump_cnt+1. Then jr=1, jmp=1, jr_addr=0x80 -> pc=0x80 (jr priority).
- pc=0x50, syscall_halt=1 -> pc=0x54, halted=1, counters frozen for 10 clocks despite bne/alu_equal=0 toggling. go held high through entry stays HALT; go 0->1 -> halted=0, next edge pc=0x58.
- rst_n pulsed low mid-HALT with counters nonzero -> immediately pc=RESET_PC, halted=0, counters 0, without a clock edge.
- (SINGLE_STEP_EN) In HALT at pc=0x54, step rising edge -> exactly one advance to 0x58, cycle_cnt+1, halted=1 again. Step and go rising together -> RUN.
